// File: rtl/bit_serial_alu.sv
// Bit-serial 32-bit ALU: samples operands, shifts them LSB-first through a 1-bit datapath, latches result.
// Optional signed/unsigned compare ops (sel 6/7) are enabled by defining SERIAL_ALU_SLT_EN.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [3:0]       w_sel,
  input  logic [WIDTH-1:0] w_rrs,
  input  logic [WIDTH-1:0] w_rrt,
  output logic [WIDTH-1:0] w_rslt
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic [3:0]     op;
  logic           carry;
  logic [CW-1:0]  cnt;
`ifdef SERIAL_ALU_SLT_EN
  logic           a_sign, b_sign;
`endif

  logic           b_bit, r_bit, carry_nxt, add_type;
  logic [WIDTH-1:0] done_val;

  // Subtract-style ops feed B inverted with an initial carry of 1 (two's complement).
  function automatic logic is_sub(input logic [3:0] sel);
    return (sel == 4'd5) || (sel == 4'd6) || (sel == 4'd7);
  endfunction

  always_comb begin
    state_nxt = state;
    b_bit     = reg_b[0] ^ is_sub(op);
    carry_nxt = (reg_a[0] & b_bit) | (reg_a[0] & carry) | (b_bit & carry);
    add_type  = (op >= 4'd4) && (op <= 4'd7);
    r_bit     = 1'b0;
    done_val  = reg_a;

    case (op)
      4'd0: r_bit = reg_a[0] & b_bit;
      4'd1: r_bit = reg_a[0] | b_bit;
      4'd2: r_bit = reg_a[0] ^ b_bit;
      4'd3: r_bit = ~(reg_a[0] | b_bit);
      4'd4, 4'd5: r_bit = reg_a[0] ^ b_bit ^ carry;
`ifdef SERIAL_ALU_SLT_EN
      4'd6, 4'd7: r_bit = reg_a[0] ^ b_bit ^ carry;
`endif
      default: r_bit = 1'b0;
    endcase

`ifdef SERIAL_ALU_SLT_EN
    // Differing signs decide directly; otherwise the difference's sign bit does.
    if (op == 4'd6)
      done_val = {{(WIDTH-1){1'b0}}, (a_sign ^ b_sign) ? a_sign : reg_a[WIDTH-1]};
    else if (op == 4'd7)
      done_val = {{(WIDTH-1){1'b0}}, ~carry};
`endif

    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      op     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      w_rslt <= '0;
`ifdef SERIAL_ALU_SLT_EN
      a_sign <= 1'b0;
      b_sign <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          reg_a <= w_rrs;
          reg_b <= w_rrt;
          op    <= w_sel;
          carry <= is_sub(w_sel);
          cnt   <= '0;
`ifdef SERIAL_ALU_SLT_EN
          a_sign <= w_rrs[WIDTH-1];
          b_sign <= w_rrt[WIDTH-1];
`endif
        end
        SHIFT: begin
          reg_a <= {r_bit, reg_a[WIDTH-1:1]};
          reg_b <= {1'b0, reg_b[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (add_type) carry <= carry_nxt;
        end
        DONE: w_rslt <= done_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: vector table, hand-written timing sequences, random ops vs. arithmetic model.
module tb_bit_serial_alu;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  w_sel;
  logic [31:0] w_rrs, w_rrt;
  logic [31:0] w_rslt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_exp = 32'd0;

  bit_serial_alu #(.WIDTH(32)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_sel (w_sel),
    .w_rrs (w_rrs),
    .w_rrt (w_rrt),
    .w_rslt(w_rslt)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  // Reference behaviour from plain arithmetic on whole words.
  function automatic logic [31:0] model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return ~(a | b);
      4'd4: return a + b;
      4'd5: return a - b;
`ifdef SERIAL_ALU_SLT_EN
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    w_sel = sel;
    w_rrs = a;
    w_rrt = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just before a LOAD edge; checks the old result is held mid-op, then the new one.
  task automatic runOp(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    applyStimulus(sel, a, b);
    repeat (11) @(posedge w_clk);
    #1 checkOutput({name, "_hold"}, w_rslt, prev_exp);
    repeat (23) @(posedge w_clk);
    #1 checkOutput(name, w_rslt, exp);
    prev_exp = exp;
  endtask

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0,          "add_wrap"};
    vecs[1]  = '{4'd5, 32'd0,         32'd1, 32'hFFFF_FFFF,  "sub_wrap"};
    vecs[2]  = '{4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};
    vecs[3]  = '{4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or"};
    vecs[4]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"};
    vecs[5]  = '{4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, "nor"};
    vecs[6]  = '{4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         "sel9"};
    vecs[7]  = '{4'd4, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, "add"};
`ifdef SERIAL_ALU_SLT_EN
    vecs[8]  = '{4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt_neg"};
    vecs[9]  = '{4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu_big"};
    vecs[10] = '{4'd6, 32'd5,         32'd9, 32'd1, "slt_pos"};
`else
    vecs[8]  = '{4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, "slt_off"};
    vecs[9]  = '{4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu_off"};
    vecs[10] = '{4'd6, 32'd5,         32'd9, 32'd0, "slt_off2"};
`endif

    w_rst = 1'b0;
    applyStimulus(4'd0, 32'd0, 32'd0);
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    checkOutput("reset", w_rslt, 32'd0);

    // Release reset; the next edge is the first LOAD.
    w_rst = 1'b1;
    runOp(4'd5, 32'd15, 32'd13, 32'd2, "sub_first");
    runOp(4'd5, 32'd15, 32'd13, 32'd2, "sub_again");

    // Hold check of this op lands on edge 79 after release.
    for (int i = 0; i < 11; i++)
      runOp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Operand change during SHIFT must not affect the running op.
    applyStimulus(4'd4, 32'd15, 32'd13);
    repeat (10) @(posedge w_clk);
    #1 w_rrs = 32'd100;
    repeat (24) @(posedge w_clk);
    #1 checkOutput("mid_change_cur", w_rslt, 32'd28);
    prev_exp = 32'd28;
    runOp(4'd4, 32'd100, 32'd13, 32'd113, "mid_change_next");

    // Reset during cycle 20 of an operation clears the result immediately.
    applyStimulus(4'd4, 32'd7, 32'd8);
    repeat (19) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b0;
    #1 checkOutput("reset_mid", w_rslt, 32'd0);
    repeat (2) @(negedge w_clk);
    w_rst = 1'b1;
    prev_exp = 32'd0;
    runOp(4'd4, 32'd7, 32'd8, 32'd15, "after_reset");

    for (int i = 0; i < 20; i++) begin
      rs = (i % 2 == 0) ? 4'($urandom_range(4, 7)) : 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      runOp(rs, ra, rb, model(rs, ra, rb), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
